conv2d_engine: RTL
==================

Name: conv2d_engine

Overview:
- Parametrised successor to the team's memory-mapped matrix convolution FSM.
- Fetches a parameter block from shared RAM and runs a 2-D convolution of matrix A with filter F.
- Adds configurable stride, zero padding, signed/unsigned arithmetic, optional ReLU and saturating writeback, with results written back to RAM.
- Sits on the same single-master read/write memory handshake as the other compute blocks.

Parameters:
- DATA_W, 32, width of memory data words and operands.
- ADDR_W, 32, width of addr_o.
- ACC_W, 64, accumulator width; must be ≥ 2*DATA_W.
- PARAM_BASE, 0, word address of the parameter block.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  start request; level-sensitive.
- mem_opdone  in  1  memory completed the current read/write this cycle.
- data_i  in  DATA_W  read data, valid when mem_opdone=1 during a read.
- data_o  out  DATA_W  write data.
- addr_o  out  ADDR_W  word address.
- mem_operation  out  2  01 read, 11 write, 00 none.
- done  out  1  run finished (success or error).
- error  out  1  invalid configuration detected.
- Power pins vccd1/vssd1 exist only under USE_POWER_PINS.

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous and active-low.
- On reset: all outputs 0, mem_operation=00 immediately, state=IDLE, all counters and buffers 0. A reset mid-transaction abandons it with no further memory activity.
- Parameter block (words at PARAM_BASE+n):
  - 0 = W (A width), 1 = H (A height), 2 = FW, 3 = FH.
  - 4 = ctrl: [3:0] stride S, [11:8] pad P, [12] relu_en, [13] signed_en.
  - A at PARAM_BASE+5, row-major. F follows at +W*H. Result follows F at +FW*FH.
- Output dimensions: OH = (H+2P-FH)/S+1, OW likewise. No divider: i and j start at 0, step by S, and continue while i+FH ≤ H+2P.
- Memory handshake:
  - Drive addr_o, mem_operation (and data_o for writes) and hold them until a rising edge with mem_opdone=1.
  - On a read, sample data_i on that edge.
  - Next cycle mem_operation=00. Every transaction is followed by at least one idle cycle.
  - mem_opdone while mem_operation=00 is ignored.
- States:
  - IDLE: enable=1 → FETCH.
  - FETCH: 5 sequential reads of words 0..4 → CHECK.
  - CHECK: W, H, FW, FH or S zero, FH > H+2P, or FW > W+2P → error=1, DONE, no writes. Otherwise → LOOP_I with accumulator cleared.
  - LOOP_I / LOOP_J / LOOP_K / LOOP_L: nested loop control as described; the K and L loops run 0..FH-1 and 0..FW-1.
  - LOAD_A: r = i+k-P, c = j+l-P. If r or c is out of range, the product is 0 and both LOAD_A and LOAD_F are skipped → LOOP_L with l+1. Otherwise read A[r][c] → LOAD_F.
  - LOAD_F: read F[k][l] → MAC.
  - MAC: one cycle; acc += op1*op2 (signed if signed_en, else unsigned) at ACC_W → LOOP_L with l+1.
  - WRITE:
    - Apply ReLU to acc (negative → 0) when relu_en.
    - Saturate to DATA_W: signed range [-2^(DATA_W-1), 2^(DATA_W-1)-1], unsigned [0, 2^DATA_W-1].
    - Write to result_base + (i/S)*OW + (j/S), tracked with separate output row/col counters.
    - Clear acc → LOOP_J.
  - DONE: done=1 (error held). Stays while enable=1; enable=0 → IDLE and clears done and error on exit.
- enable falling mid-run is ignored until DONE. enable held high in DONE does not restart.
- All address arithmetic wraps modulo 2^ADDR_W.

Test Plan:
- A 3x3 = 1..9, F 2x2 = [1,0;0,1], S=1, P=0, unsigned → writes 6, 8, 12, 14 at addresses 18..21; 4 writes; done=1, error=0.
- A 4x4 all 1, F 2x2 all 1, S=2, P=0 → exactly 4 writes of value 4 at addresses 25..28.
- A 2x2 all 1, F 3x3 all 1, S=1, P=1 → 2x2 output all 4; exactly 16 A reads and 16 F reads (padded taps cause no memory traffic).
- DATA_W=8, 1x1 A = -100 (0x9C), F = 2, signed: relu off → 0x80; relu on → 0x00. Unsigned A=200, F=2 → 0xFF.
- FW=FH=4 on a 3x3 A with P=0, or S=0 → error=1, done=1 after the 5 parameter reads, zero write transactions.
- reset_n pulled low while LOAD_A waits on mem_opdone → mem_operation=00 asynchronously, done=0. After release and a new enable, the first test case reproduces the same results; holding mem_opdone low 10 cycles per transaction gives identical results.

Source files
------------

// File: rtl/conv2d_engine.sv
// Memory-mapped 2-D convolution engine: fetches a parameter block, then convolves A with F
// using stride, zero padding, signed/unsigned MAC, optional ReLU and saturating writeback.
module conv2d_engine #(
  parameter int                 DATA_W     = 32,
  parameter int                 ADDR_W     = 32,
  parameter int                 ACC_W      = 64,
  parameter logic [ADDR_W-1:0]  PARAM_BASE = '0
) (
`ifdef USE_POWER_PINS
  inout  wire                vccd1,
  inout  wire                vssd1,
`endif
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               mem_opdone,
  input  logic [DATA_W-1:0]  data_i,
  output logic [DATA_W-1:0]  data_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [1:0]         mem_operation,
  output logic               done,
  output logic               error
);

  localparam int EW = DATA_W + 5;
  localparam int SW = EW + 1;
  localparam logic [ADDR_W-1:0] A_BASE = PARAM_BASE + ADDR_W'(5);
  localparam logic [ACC_W-1:0]  SMAX   = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic [ACC_W-1:0]  SMIN   = ~SMAX;
  localparam logic [ACC_W-1:0]  UMAX   = (ACC_W'(1) << DATA_W) - ACC_W'(1);

  typedef enum logic [3:0] {
    IDLE, FETCH, CHECK, LOOP_I, LOOP_J, LOOP_K, LOOP_L, LOAD_A, LOAD_F, MAC, WRITE, DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] w, h, fw, fh, op_a, op_f;
  logic [3:0]        stride, pad;
  logic              relu_en, sgn_en;
  logic [EW-1:0]     i, j, k, l;
  logic [ACC_W-1:0]  acc;
  logic [ADDR_W-1:0] f_base, out_ptr;
  logic [2:0]        fcnt;
  logic              gap, error_r;

  logic [EW-1:0]     h_pad, w_pad;
  logic              row_ok, col_ok, cfg_bad, tap_ok, xfer;
  logic signed [SW-1:0] r_s, c_s;
  logic [ADDR_W-1:0] a_addr, f_addr, f_base_c;
  logic [ACC_W-1:0]  ext_a, ext_f, prod, acc_r;
  logic [DATA_W-1:0] sat_val;

  always_comb begin
    h_pad    = EW'(h) + EW'({pad, 1'b0});
    w_pad    = EW'(w) + EW'({pad, 1'b0});
    row_ok   = (i + EW'(fh)) <= h_pad;
    col_ok   = (j + EW'(fw)) <= w_pad;
    cfg_bad  = (w == '0) || (h == '0) || (fw == '0) || (fh == '0) || (stride == '0) ||
               (EW'(fh) > h_pad) || (EW'(fw) > w_pad);
    r_s      = $signed({1'b0, i}) + $signed({1'b0, k}) - $signed(SW'(pad));
    c_s      = $signed({1'b0, j}) + $signed({1'b0, l}) - $signed(SW'(pad));
    tap_ok   = !r_s[SW-1] && (r_s < $signed(SW'(h))) && !c_s[SW-1] && (c_s < $signed(SW'(w)));
    a_addr   = A_BASE + ADDR_W'(r_s) * ADDR_W'(w) + ADDR_W'(c_s);
    f_addr   = f_base + ADDR_W'(k) * ADDR_W'(fw) + ADDR_W'(l);
    f_base_c = A_BASE + ADDR_W'(w) * ADDR_W'(h);
    // Low ACC_W bits of the product are identical for signed and unsigned once operands are extended
    ext_a    = sgn_en ? {{(ACC_W-DATA_W){op_a[DATA_W-1]}}, op_a} : ACC_W'(op_a);
    ext_f    = sgn_en ? {{(ACC_W-DATA_W){op_f[DATA_W-1]}}, op_f} : ACC_W'(op_f);
    prod     = ext_a * ext_f;
    acc_r    = (relu_en && sgn_en && acc[ACC_W-1]) ? '0 : acc;
    if (sgn_en) begin
      if ($signed(acc_r) > $signed(SMAX))      sat_val = DATA_W'(SMAX);
      else if ($signed(acc_r) < $signed(SMIN)) sat_val = DATA_W'(SMIN);
      else                                     sat_val = DATA_W'(acc_r);
    end else begin
      sat_val = (acc_r > UMAX) ? DATA_W'(UMAX) : DATA_W'(acc_r);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    mem_operation = 2'b00;
    addr_o        = '0;
    data_o        = '0;
    case (state)
      IDLE:   if (enable) state_nx = FETCH;
      FETCH:  if (!gap) begin
                mem_operation = 2'b01;
                addr_o        = PARAM_BASE + ADDR_W'(fcnt);
                if (mem_opdone && fcnt == 3'd4) state_nx = CHECK;
              end
      CHECK:  state_nx = cfg_bad ? DONE : LOOP_I;
      LOOP_I: state_nx = row_ok ? LOOP_J : DONE;
      LOOP_J: state_nx = col_ok ? LOOP_K : LOOP_I;
      LOOP_K: state_nx = (k < EW'(fh)) ? LOOP_L : WRITE;
      LOOP_L: state_nx = (l < EW'(fw)) ? LOAD_A : LOOP_K;
      LOAD_A: if (!tap_ok) state_nx = LOOP_L;
              else if (!gap) begin
                mem_operation = 2'b01;
                addr_o        = a_addr;
                if (mem_opdone) state_nx = LOAD_F;
              end
      LOAD_F: if (!gap) begin
                mem_operation = 2'b01;
                addr_o        = f_addr;
                if (mem_opdone) state_nx = MAC;
              end
      MAC:    state_nx = LOOP_L;
      WRITE:  if (!gap) begin
                mem_operation = 2'b11;
                addr_o        = out_ptr;
                data_o        = sat_val;
                if (mem_opdone) state_nx = LOOP_J;
              end
      DONE:   if (!enable) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign xfer  = mem_opdone && (mem_operation != 2'b00);
  assign done  = (state == DONE);
  assign error = error_r;

  // Results land in row-major order, so a running pointer replaces row*OW+col
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w <= '0; h <= '0; fw <= '0; fh <= '0; op_a <= '0; op_f <= '0;
      stride <= '0; pad <= '0; relu_en <= 1'b0; sgn_en <= 1'b0;
      i <= '0; j <= '0; k <= '0; l <= '0; acc <= '0;
      f_base <= '0; out_ptr <= '0; fcnt <= '0; gap <= 1'b0; error_r <= 1'b0;
    end else begin
      gap <= xfer;
      case (state)
        IDLE:   if (enable) begin
                  fcnt    <= '0;
                  error_r <= 1'b0;
                end
        FETCH:  if (xfer) begin
                  case (fcnt)
                    3'd0: w  <= data_i;
                    3'd1: h  <= data_i;
                    3'd2: fw <= data_i;
                    3'd3: fh <= data_i;
                    default: begin
                      stride  <= 4'(data_i);
                      pad     <= 4'(data_i >> 8);
                      relu_en <= 1'(data_i >> 12);
                      sgn_en  <= 1'(data_i >> 13);
                    end
                  endcase
                  fcnt <= fcnt + 3'd1;
                end
        CHECK:  if (cfg_bad) error_r <= 1'b1;
                else begin
                  i       <= '0;
                  acc     <= '0;
                  f_base  <= f_base_c;
                  out_ptr <= f_base_c + ADDR_W'(fw) * ADDR_W'(fh);
                end
        LOOP_I: if (row_ok) j <= '0;
        LOOP_J: if (col_ok) k <= '0;
                else        i <= i + EW'(stride);
        LOOP_K: if (k < EW'(fh)) l <= '0;
        LOOP_L: if (!(l < EW'(fw))) k <= k + EW'(1);
        LOAD_A: if (!tap_ok)  l    <= l + EW'(1);
                else if (xfer) op_a <= data_i;
        LOAD_F: if (xfer) op_f <= data_i;
        MAC:    begin
                  acc <= acc + prod;
                  l   <= l + EW'(1);
                end
        WRITE:  if (xfer) begin
                  acc     <= '0;
                  out_ptr <= out_ptr + ADDR_W'(1);
                  j       <= j + EW'(stride);
                end
        DONE:   if (!enable) error_r <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
